led_sequencer: RTL and testbench

Controller that drives the 4-LED Dock bank from the 27 MHz board clock and two push-buttons. It owns the tick timebase and steps a 4-bit pattern register each tick, in one of four modes: count up, count down, chase or blink. A debounced MODE button cycles the mode and a debounced PAUSE button freezes or resumes stepping. It sits between the board pins and IO_voltage, replacing the free-running counter as the LED source.

---
 rtl/led_pkg.sv | 59 +++++
 rtl/button_debounce.sv | 66 ++++++
 rtl/led_sequencer.sv | 94 +++++++++
 tb/tb_led_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types, constants and pattern helpers for the LED sequencer.
package led_pkg;

    // Pattern modes, in the order the MODE button cycles through them
    typedef enum logic [1:0] {
        MODE_UP    = 2'd0,
        MODE_DOWN  = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

    // Pattern loaded when a mode is entered
    localparam logic [3:0] INIT_UP    = 4'h0;
    localparam logic [3:0] INIT_DOWN  = 4'hF;
    localparam logic [3:0] INIT_CHASE = 4'h1;
    localparam logic [3:0] INIT_BLINK = 4'h0;

    // Flip-flops in each button synchronizer chain
    localparam int SYNC_STAGES = 2;

    // Button slots in the debouncer array
    localparam int BTN_MODE  = 0;
    localparam int BTN_PAUSE = 1;
    localparam int BTN_COUNT = 2;

    // Pattern after one tick in the given mode
    function automatic logic [3:0] next_pattern(input mode_t mode, input logic [3:0] pattern);
        logic [3:0] result;
        result = pattern;
        case (mode)
            MODE_UP:    result = pattern + 4'd1;
            MODE_DOWN:  result = pattern - 4'd1;
            MODE_CHASE: result = {pattern[2:0], pattern[3]};
            MODE_BLINK: result = ~pattern;
            default:    result = pattern;
        endcase
        return result;
    endfunction

    // Pattern shown on entry to a mode
    function automatic logic [3:0] init_pattern(input mode_t mode);
        logic [3:0] result;
        result = INIT_UP;
        case (mode)
            MODE_UP:    result = INIT_UP;
            MODE_DOWN:  result = INIT_DOWN;
            MODE_CHASE: result = INIT_CHASE;
            MODE_BLINK: result = INIT_BLINK;
            default:    result = INIT_UP;
        endcase
        return result;
    endfunction

    // Mode that follows the given one, wrapping BLINK back to UP
    function automatic mode_t next_mode(input mode_t mode);
        return mode_t'(mode + 2'd1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes a raw push-button, debounces it and emits a one-cycle
// pulse on each accepted press (0->1 of the debounced level).
import led_pkg::*;

module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 270_000
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic raw_in,
    output logic level,
    output logic press
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1 before the flip
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   level_reg;
    logic                   prev_reg;
    logic                   press_reg;

    logic sync_level;
    assign sync_level = sync_reg[SYNC_STAGES-1];

    // Bring the asynchronous button into the Clock domain
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in};
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else if (sync_level == level_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            level_reg <= ~level_reg;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Registered rising-edge detect on the debounced level; releases give no pulse
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_reg  <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            prev_reg  <= level_reg;
            press_reg <= level_reg & ~prev_reg;
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/led_sequencer.sv
// LED bank controller: tick timebase, mode/run control and 4-bit pattern
// register, driven by debounced MODE and PAUSE buttons.
import led_pkg::*;

module led_sequencer #(
    parameter int unsigned TICK_MAX        = 13_500_000,
    parameter int unsigned DEBOUNCE_CYCLES = 270_000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Button_mode,
    input  logic       Button_pause,
    output logic [3:0] IO_voltage,
    output logic [1:0] Mode,
    output logic       Running
);

    localparam int TICK_W = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAX - 1);

    logic [BTN_COUNT-1:0] btn_raw;
    logic [BTN_COUNT-1:0] btn_press;
    logic [BTN_COUNT-1:0] btn_level_unused;

    logic [TICK_W-1:0] tick_cnt_reg;
    mode_t             mode_reg;
    logic [3:0]        pattern_reg;
    logic              running_reg;

    logic mode_press;
    logic pause_press;
    logic tick;

    assign btn_raw[BTN_MODE]  = Button_mode;
    assign btn_raw[BTN_PAUSE] = Button_pause;

    // One synchronizer/debouncer per button; only the press pulses are consumed here
    generate
        for (genvar gi = 0; gi < BTN_COUNT; gi++) begin : g_button
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .Clock   (Clock),
                .Reset_n (Reset_n),
                .raw_in  (btn_raw[gi]),
                .level   (btn_level_unused[gi]),
                .press   (btn_press[gi])
            );
        end
    endgenerate

    assign mode_press  = btn_press[BTN_MODE];
    assign pause_press = btn_press[BTN_PAUSE];
    assign tick        = running_reg && (tick_cnt_reg == TICK_LAST);

    // Tick timebase: restarts on a mode change, holds its place while paused
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_cnt_reg <= '0;
        end else if (mode_press) begin
            tick_cnt_reg <= '0;
        end else if (running_reg) begin
            if (tick_cnt_reg == TICK_LAST) begin
                tick_cnt_reg <= '0;
            end else begin
                tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
            end
        end
    end

    // Mode, run state and pattern; a mode change overrides a same-cycle step
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_reg    <= MODE_UP;
            pattern_reg <= INIT_UP;
            running_reg <= 1'b1;
        end else begin
            if (mode_press) begin
                mode_reg    <= next_mode(mode_reg);
                pattern_reg <= init_pattern(next_mode(mode_reg));
            end else if (tick) begin
                pattern_reg <= next_pattern(mode_reg, pattern_reg);
            end
            if (pause_press) begin
                running_reg <= ~running_reg;
            end
        end
    end

    assign IO_voltage = pattern_reg;
    assign Mode       = mode_reg;
    assign Running    = running_reg;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with TICK_MAX=8, DEBOUNCE_CYCLES=4.
// Edge numbers in comments count rising edges after reset release.
module tb_led_sequencer;

    logic       clk;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_pause;
    logic [3:0] io_voltage;
    logic [1:0] mode;
    logic       running;

    int total = 0;
    int bad   = 0;

    led_sequencer #(
        .TICK_MAX        (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .Clock        (clk),
        .Reset_n      (rst_n),
        .Button_mode  (btn_mode),
        .Button_pause (btn_pause),
        .IO_voltage   (io_voltage),
        .Mode         (mode),
        .Running      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end else begin
            $display("ok   %s: got=%b", tag, got);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] io_exp,
                             input logic [1:0] mode_exp, input logic run_exp);
        check_val({tag, ".io"},   io_voltage,    io_exp);
        check_val({tag, ".mode"}, 4'(mode),      4'(mode_exp));
        check_val({tag, ".run"},  4'(running),   4'(run_exp));
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_mode  = 1'b0;
        btn_pause = 1'b0;
        step(3);
        check_all("reset", 4'b0000, 2'd0, 1'b1);
        rst_n = 1'b1;                                   // edge 0

        // 1: free-run UP, one step every 8 edges
        for (int k = 1; k <= 17; k++) begin
            step(7);
            check_val($sformatf("up_hold%0d", k), io_voltage, 4'(k - 1));
            step(1);
            check_val($sformatf("up_step%0d", k), io_voltage, 4'(k));
        end                                             // edge 136, io=0001

        // 2: MODE press to DOWN, then to CHASE
        step(2);                                        // edge 138
        btn_mode = 1'b1;
        step(6);                                        // edge 144: tick
        check_all("pre_down", 4'b0010, 2'd0, 1'b1);
        step(1);
        check_val("pre_down.mode", 4'(mode), 4'd0);
        step(1);                                        // edge 146: press
        check_all("down_entry", 4'b1111, 2'd1, 1'b1);
        step(2);                                        // edge 148
        btn_mode = 1'b0;
        step(5);                                        // edge 153
        check_val("down_hold", io_voltage, 4'b1111);
        step(1);                                        // edge 154
        check_val("down_step", io_voltage, 4'b1110);
        btn_mode = 1'b1;
        step(7);                                        // edge 161
        check_all("pre_chase", 4'b1110, 2'd1, 1'b1);
        step(1);                                        // edge 162
        check_all("chase_entry", 4'b0001, 2'd2, 1'b1);
        step(2);
        btn_mode = 1'b0;                                // edge 164
        step(6);
        check_val("chase1", io_voltage, 4'b0010);       // edge 170
        step(8);
        check_val("chase2", io_voltage, 4'b0100);
        step(8);
        check_val("chase3", io_voltage, 4'b1000);
        step(8);
        check_val("chase_wrap", io_voltage, 4'b0001);   // edge 194

        // 3: short glitch, then bouncing edge before a stable press
        btn_mode = 1'b1;
        step(3);
        btn_mode = 1'b0;                                // edge 197
        step(10);                                       // edge 207
        check_all("glitch", 4'b0010, 2'd2, 1'b1);
        btn_mode = 1'b1; step(2);
        btn_mode = 1'b0; step(2);
        btn_mode = 1'b1; step(2);
        btn_mode = 1'b0; step(2);
        btn_mode = 1'b1;                                // edge 215
        step(7);
        check_val("bounce_pre", 4'(mode), 4'd2);        // edge 222
        step(1);
        check_all("blink_entry", 4'b0000, 2'd3, 1'b1);  // edge 223
        step(2);
        btn_mode = 1'b0;                                // edge 225
        step(6);
        check_all("blink1", 4'b1111, 2'd3, 1'b1);       // edge 231
        step(8);
        check_all("blink2", 4'b0000, 2'd3, 1'b1);       // edge 239

        // 5: mode wraps BLINK->UP on a tick edge, then press aligned with tick at 0101
        btn_mode = 1'b1;
        step(8);
        check_all("wrap_tick", 4'b0000, 2'd0, 1'b1);    // edge 247
        step(2);
        btn_mode = 1'b0;                                // edge 249
        step(38);
        check_val("up_0101", io_voltage, 4'b0101);      // edge 287
        btn_mode = 1'b1;
        step(7);
        check_val("align_pre", io_voltage, 4'b0101);    // edge 294
        step(1);
        check_all("align_tick", 4'b1111, 2'd1, 1'b1);   // edge 295
        step(2);
        btn_mode = 1'b0;                                // edge 297
        step(5);
        check_val("align_hold", io_voltage, 4'b1111);   // edge 302
        step(1);
        check_val("align_next", io_voltage, 4'b1110);   // edge 303

        // 4: pause with counter at 5, hold 50 cycles, resume keeps remaining interval
        step(5);
        btn_pause = 1'b1;                               // edge 308
        step(8);
        check_all("paused", 4'b1101, 2'd1, 1'b0);       // edge 316
        step(2);
        btn_pause = 1'b0;                               // edge 318
        step(48);
        check_all("frozen", 4'b1101, 2'd1, 1'b0);       // edge 366
        btn_pause = 1'b1;
        step(8);
        check_all("resumed", 4'b1101, 2'd1, 1'b1);      // edge 374
        step(2);
        btn_pause = 1'b0;                               // edge 376
        check_val("resume_hold", io_voltage, 4'b1101);
        step(1);
        check_val("resume_step", io_voltage, 4'b1100);  // edge 377

        // 6: reach BLINK at 1111, start a debounce, then reset mid-cycle
        btn_mode = 1'b1;
        step(8);
        check_val("to_chase.mode", 4'(mode), 4'd2);     // edge 385
        step(2);
        btn_mode = 1'b0;                                // edge 387
        step(6);
        btn_mode = 1'b1;                                // edge 393
        step(8);
        check_all("to_blink", 4'b0000, 2'd3, 1'b1);     // edge 401
        step(2);
        btn_mode = 1'b0;
        step(6);
        check_val("blink_on", io_voltage, 4'b1111);     // edge 409
        btn_mode = 1'b1;
        step(3);                                        // debounce counting
        #3;
        rst_n    = 1'b0;
        btn_mode = 1'b0;
        #1;
        check_all("async_rst", 4'b0000, 2'd0, 1'b1);
        step(2);
        rst_n = 1'b1;
        step(12);
        check_all("post_rst", 4'b0001, 2'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
